// File: rtl/zipdma_mc_fsm_if.sv
`default_nettype none
// ============================================================================
// zipdma_mc_fsm_if : control bundle between the DMA FSM and its MM2S/S2MM engines
// Revision : 1.0
// ============================================================================
interface zipdma_mc_fsm_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int LGSUBLENGTH   = 10
);
   logic                     o_mm2s_request;
   logic                     i_mm2s_busy;
   logic                     i_mm2s_err;
   logic                     i_mm2s_inc;
   logic [ADDRESS_WIDTH-1:0] o_mm2s_addr;
   logic [LGSUBLENGTH:0]     o_mm2s_transferlen;

   logic                     o_s2mm_request;
   logic                     i_s2mm_busy;
   logic                     i_s2mm_err;
   logic                     i_s2mm_inc;
   logic [ADDRESS_WIDTH-1:0] o_s2mm_addr;
   logic [LGSUBLENGTH:0]     o_s2mm_transferlen;

   modport master (
      output o_mm2s_request, o_mm2s_addr, o_mm2s_transferlen,
      input  i_mm2s_busy, i_mm2s_err, i_mm2s_inc,
      output o_s2mm_request, o_s2mm_addr, o_s2mm_transferlen,
      input  i_s2mm_busy, i_s2mm_err, i_s2mm_inc
   );

   modport slave (
      input  o_mm2s_request, o_mm2s_addr, o_mm2s_transferlen,
      output i_mm2s_busy, i_mm2s_err, i_mm2s_inc,
      input  o_s2mm_request, o_s2mm_addr, o_s2mm_transferlen,
      output i_s2mm_busy, i_s2mm_err, i_s2mm_inc
   );
endinterface
`default_nettype wire

// File: rtl/zipdma_mc_fsm.sv
`default_nettype none
// ============================================================================
// zipdma_mc_fsm : multi-channel DMA control FSM, round-robin over shared engines
// Revision : 1.0
// ============================================================================
module zipdma_mc_fsm #(
   parameter int NCHAN         = 4,
   parameter int ADDRESS_WIDTH = 32,
   parameter int LGDMALENGTH   = ADDRESS_WIDTH,
   parameter int LGSUBLENGTH   = 10
) (
   input  logic                           i_clk,
   input  logic                           i_reset_n,
   input  logic [NCHAN-1:0]               i_request,
   input  logic [NCHAN-1:0]               i_abort,
   input  logic [NCHAN-1:0]               i_trigger,
   input  logic [NCHAN*ADDRESS_WIDTH-1:0] i_src_addr,
   input  logic [NCHAN*ADDRESS_WIDTH-1:0] i_dst_addr,
   input  logic [NCHAN*LGDMALENGTH-1:0]   i_length,
   input  logic [LGSUBLENGTH:0]           i_transferlen,
   output logic [NCHAN-1:0]               o_busy,
   output logic [NCHAN-1:0]               o_done,
   output logic [NCHAN-1:0]               o_err,
   output logic [NCHAN*LGDMALENGTH-1:0]   o_remaining_len,
   zipdma_mc_fsm_if.master                eng
);
   localparam int AW  = ADDRESS_WIDTH;
   localparam int LW  = LGDMALENGTH;
   localparam int SLW = LGSUBLENGTH + 1;
   localparam int CW  = (LW > SLW) ? LW : SLW;
   localparam int IW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam logic [SLW-1:0] TL_MAX = {1'b1, {LGSUBLENGTH{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [SLW-1:0]    xfer_q, xfer_d;
   logic              mm2s_req_q, mm2s_req_d;
   logic              s2mm_req_q, s2mm_req_d;
   logic [AW-1:0]     mm2s_addr_q, mm2s_addr_d;
   logic [AW-1:0]     s2mm_addr_q, s2mm_addr_d;
   logic [NCHAN-1:0]  busy_q, busy_d;
   logic [NCHAN-1:0]  done_q, done_d;
   logic [NCHAN-1:0]  err_q, err_d;
   logic [NCHAN-1:0]  abort_pend_q, abort_pend_d;
   logic [AW-1:0]     src_q [NCHAN];
   logic [AW-1:0]     src_d [NCHAN];
   logic [AW-1:0]     dst_q [NCHAN];
   logic [AW-1:0]     dst_d [NCHAN];
   logic [LW-1:0]     len_q [NCHAN];
   logic [LW-1:0]     len_d [NCHAN];

   logic [NCHAN-1:0]  eligible;
   logic              found;
   logic [IW-1:0]     pick;
   logic [IW-1:0]     scan;
   int                scan_i;
   logic [SLW-1:0]    tl_eff;
   logic [CW-1:0]     len_ext;
   logic [CW-1:0]     tl_ext;
   logic [SLW-1:0]    xfer_new;
   logic [LW-1:0]     new_len;
   logic              active;

   assign active   = (state_q != S_IDLE);
   assign eligible = busy_q & ~abort_pend_q & ~i_abort & i_trigger;
   assign tl_eff   = (i_transferlen == '0) ? TL_MAX : i_transferlen;

   // Search starts at ptr_q, which always points one past the last grant.
   always_comb begin
      found  = 1'b0;
      pick   = '0;
      scan   = '0;
      scan_i = 0;
      for (int k = 0; k < NCHAN; k++) begin
         scan_i = int'(ptr_q) + k;
         if (scan_i >= NCHAN) scan_i = scan_i - NCHAN;
         scan = IW'(scan_i);
         if (!found && eligible[scan]) begin
            found = 1'b1;
            pick  = scan;
         end
      end
   end

   always_comb begin
      len_ext  = CW'(len_q[pick]);
      tl_ext   = CW'(tl_eff);
      xfer_new = (len_ext < tl_ext) ? SLW'(len_ext) : tl_eff;
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      ptr_d        = ptr_q;
      xfer_d       = xfer_q;
      mm2s_req_d   = mm2s_req_q;
      s2mm_req_d   = s2mm_req_q;
      mm2s_addr_d  = mm2s_addr_q;
      s2mm_addr_d  = s2mm_addr_q;
      busy_d       = busy_q;
      err_d        = err_q;
      abort_pend_d = abort_pend_q;
      done_d       = '0;
      src_d        = src_q;
      dst_d        = dst_q;
      len_d        = len_q;
      new_len      = len_q[grant_q] - LW'(xfer_q);

      for (int c = 0; c < NCHAN; c++) begin
         if (i_abort[c]) begin
            if (active && (grant_q == IW'(c))) abort_pend_d[c] = 1'b1;
            else                                busy_d[c]       = 1'b0;
         end else if (i_request[c] && !busy_q[c]) begin
            src_d[c] = i_src_addr[c*AW +: AW];
            dst_d[c] = i_dst_addr[c*AW +: AW];
            len_d[c] = i_length[c*LW +: LW];
            err_d[c] = 1'b0;
            if (i_length[c*LW +: LW] == '0) done_d[c] = 1'b1;
            else                            busy_d[c] = 1'b1;
         end
      end

      // An engine error outranks any completion seen in the same cycle.
      if (active && (eng.i_mm2s_err || eng.i_s2mm_err)) begin
         busy_d[grant_q]       = 1'b0;
         err_d[grant_q]        = 1'b1;
         abort_pend_d[grant_q] = 1'b0;
         mm2s_req_d            = 1'b0;
         s2mm_req_d            = 1'b0;
         state_d               = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (found) begin
                  grant_d     = pick;
                  ptr_d       = (int'(pick) == NCHAN - 1) ? '0 : pick + 1'b1;
                  xfer_d      = xfer_new;
                  mm2s_addr_d = src_q[pick];
                  mm2s_req_d  = 1'b1;
                  state_d     = S_READ;
               end
            end
            S_READ: begin
               if (!eng.i_mm2s_busy) begin
                  if (mm2s_req_q) begin
                     mm2s_req_d = 1'b0;
                  end else begin
                     if (eng.i_mm2s_inc)
                        src_d[grant_q] = src_q[grant_q] + AW'(xfer_q);
                     s2mm_addr_d = dst_q[grant_q];
                     s2mm_req_d  = 1'b1;
                     state_d     = S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (!eng.i_s2mm_busy) begin
                  if (s2mm_req_q) begin
                     s2mm_req_d = 1'b0;
                  end else begin
                     if (eng.i_s2mm_inc)
                        dst_d[grant_q] = dst_q[grant_q] + AW'(xfer_q);
                     len_d[grant_q] = new_len;
                     state_d        = S_IDLE;
                     if (abort_pend_q[grant_q] || i_abort[grant_q]) begin
                        busy_d[grant_q]       = 1'b0;
                        abort_pend_d[grant_q] = 1'b0;
                     end else if (new_len == '0) begin
                        busy_d[grant_q] = 1'b0;
                        done_d[grant_q] = 1'b1;
                     end
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         ptr_q        <= '0;
         xfer_q       <= '0;
         mm2s_req_q   <= 1'b0;
         s2mm_req_q   <= 1'b0;
         mm2s_addr_q  <= '0;
         s2mm_addr_q  <= '0;
         busy_q       <= '0;
         done_q       <= '0;
         err_q        <= '0;
         abort_pend_q <= '0;
         for (int c = 0; c < NCHAN; c++) begin
            src_q[c] <= '0;
            dst_q[c] <= '0;
            len_q[c] <= '0;
         end
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         ptr_q        <= ptr_d;
         xfer_q       <= xfer_d;
         mm2s_req_q   <= mm2s_req_d;
         s2mm_req_q   <= s2mm_req_d;
         mm2s_addr_q  <= mm2s_addr_d;
         s2mm_addr_q  <= s2mm_addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         abort_pend_q <= abort_pend_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         len_q        <= len_d;
      end
   end

   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_err  = err_q;

   generate
      for (genvar c = 0; c < NCHAN; c++) begin : g_rem
         assign o_remaining_len[c*LW +: LW] = len_q[c];
      end
   endgenerate

   assign eng.o_mm2s_request     = mm2s_req_q;
   assign eng.o_mm2s_addr        = mm2s_addr_q;
   assign eng.o_mm2s_transferlen = xfer_q;
   assign eng.o_s2mm_request     = s2mm_req_q;
   assign eng.o_s2mm_addr        = s2mm_addr_q;
   assign eng.o_s2mm_transferlen = xfer_q;
endmodule
`default_nettype wire

// File: tb/tb_zipdma_mc_fsm.sv
`default_nettype none
// tb_zipdma_mc_fsm : directed bench; engine models ack each request after 3 busy cycles.
module tb_zipdma_mc_fsm;
   localparam int NCH = 4;
   localparam int AW  = 32;
   localparam int LW  = 32;
   localparam int LGS = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [NCH-1:0]    request, abort_s, trigger;
   logic [NCH*AW-1:0] src, dst;
   logic [NCH*LW-1:0] length;
   logic [LGS:0]      tl;
   wire  [NCH-1:0]    busy, done, err;
   wire  [NCH*LW-1:0] rem;

   zipdma_mc_fsm_if #(.ADDRESS_WIDTH(AW), .LGSUBLENGTH(LGS)) bus ();

   zipdma_mc_fsm #(.NCHAN(NCH), .ADDRESS_WIDTH(AW), .LGDMALENGTH(LW), .LGSUBLENGTH(LGS)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_request(request), .i_abort(abort_s), .i_trigger(trigger),
      .i_src_addr(src), .i_dst_addr(dst), .i_length(length), .i_transferlen(tl),
      .o_busy(busy), .o_done(done), .o_err(err), .o_remaining_len(rem),
      .eng(bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] rd_addr_q [$];
   logic [31:0] wr_addr_q [$];
   logic [LGS:0] rd_len_q [$];
   int done_cnt [NCH];
   int done_order [$];
   int rd_cnt, wr_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.i_mm2s_busy <= 1'b0;
         rd_cnt          <= 0;
      end else if (bus.i_mm2s_busy) begin
         if (rd_cnt <= 1) bus.i_mm2s_busy <= 1'b0;
         else             rd_cnt <= rd_cnt - 1;
      end else if (bus.o_mm2s_request) begin
         bus.i_mm2s_busy <= 1'b1;
         rd_cnt          <= 3;
         rd_addr_q.push_back(bus.o_mm2s_addr);
         rd_len_q.push_back(bus.o_mm2s_transferlen);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.i_s2mm_busy <= 1'b0;
         wr_cnt          <= 0;
      end else if (bus.i_s2mm_busy) begin
         if (wr_cnt <= 1) bus.i_s2mm_busy <= 1'b0;
         else             wr_cnt <= wr_cnt - 1;
      end else if (bus.o_s2mm_request) begin
         bus.i_s2mm_busy <= 1'b1;
         wr_cnt          <= 3;
         wr_addr_q.push_back(bus.o_s2mm_addr);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            if (done[c]) begin
               done_cnt[c] = done_cnt[c] + 1;
               done_order.push_back(c);
            end
         end
      end
   end

   task automatic apply_reset();
      rst_n          = 1'b0;
      request        = '0;
      abort_s        = '0;
      trigger        = '1;
      src            = '0;
      dst            = '0;
      length         = '0;
      tl             = 11'd1024;
      bus.i_mm2s_err = 1'b0;
      bus.i_s2mm_err = 1'b0;
      bus.i_mm2s_inc = 1'b1;
      bus.i_s2mm_inc = 1'b1;
      repeat (2) @(negedge clk);
      rd_addr_q.delete();
      wr_addr_q.delete();
      rd_len_q.delete();
      done_order.delete();
      for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic load(input int c, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
      src[c*AW +: AW]    = s;
      dst[c*AW +: AW]    = d;
      length[c*LW +: LW] = l;
   endtask

   task automatic wait_idle(input logic [NCH-1:0] mask, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if ((busy & mask) == '0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_mm2s(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.o_mm2s_request) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_s2mm(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.o_s2mm_request) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (busy !== 4'h0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
      checks++; if (done !== 4'h0 || err !== 4'h0) begin failures++; $display("FAIL reset_done_err got=%0h/%0h exp=0/0", done, err); end
      checks++; if (rem !== '0) begin failures++; $display("FAIL reset_rem got=%0h exp=0", rem); end
      checks++; if (bus.o_mm2s_request !== 1'b0 || bus.o_s2mm_request !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b%0b exp=00", bus.o_mm2s_request, bus.o_s2mm_request); end
      checks++; if (bus.o_mm2s_addr !== 32'h0 || bus.o_mm2s_transferlen !== 11'h0) begin failures++; $display("FAIL reset_addr_len got=%0h/%0h exp=0/0", bus.o_mm2s_addr, bus.o_mm2s_transferlen); end
   endtask

   task automatic test_single();
      bit ok;
      logic [31:0] ea [3];
      logic [31:0] ew [3];
      logic [LGS:0] el [3];
      ea = '{32'h1000, 32'h1400, 32'h1800};
      ew = '{32'h8000, 32'h8400, 32'h8800};
      el = '{11'd1024, 11'd1024, 11'd452};
      apply_reset();
      load(0, 32'h1000, 32'h8000, 32'd2500);
      request[0] = 1'b1;
      @(negedge clk);
      request[0] = 1'b0;
      checks++; if (busy[0] !== 1'b1 || bus.o_mm2s_request !== 1'b0) begin failures++; $display("FAIL single_accept busy/req got=%0b/%0b exp=1/0", busy[0], bus.o_mm2s_request); end
      @(negedge clk);
      checks++; if (bus.o_mm2s_request !== 1'b1 || bus.o_mm2s_addr !== 32'h1000) begin failures++; $display("FAIL single_grant req/addr got=%0b/%0h exp=1/1000", bus.o_mm2s_request, bus.o_mm2s_addr); end
      checks++; if (bus.o_mm2s_transferlen !== 11'd1024) begin failures++; $display("FAIL single_tl got=%0d exp=1024", bus.o_mm2s_transferlen); end
      wait_idle(4'b0001, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_timeout busy got=%0h exp=0", busy); end
      repeat (2) @(negedge clk);
      checks++; if (rd_addr_q.size() != 3 || wr_addr_q.size() != 3) begin failures++; $display("FAIL single_count got=%0d/%0d exp=3/3", rd_addr_q.size(), wr_addr_q.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= rd_addr_q.size() || rd_addr_q[i] !== ea[i] || rd_len_q[i] !== el[i]) begin
            failures++;
            $display("FAIL single_rd[%0d] got=%0h/%0d exp=%0h/%0d", i, (i < rd_addr_q.size()) ? rd_addr_q[i] : 32'hDEADBEEF, (i < rd_len_q.size()) ? rd_len_q[i] : 11'h0, ea[i], el[i]);
         end
         checks++;
         if (i >= wr_addr_q.size() || wr_addr_q[i] !== ew[i]) begin
            failures++;
            $display("FAIL single_wr[%0d] got=%0h exp=%0h", i, (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hDEADBEEF, ew[i]);
         end
      end
      checks++; if (done_cnt[0] != 1) begin failures++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt[0]); end
      checks++; if (rem[31:0] !== 32'd0) begin failures++; $display("FAIL single_rem got=%0d exp=0", rem[31:0]); end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [31:0] ea [3];
      ea = '{32'h10000, 32'h20000, 32'h10400};
      apply_reset();
      load(0, 32'h10000, 32'h11000, 32'd2048);
      load(2, 32'h20000, 32'h21000, 32'd1024);
      request = 4'b0101;
      @(negedge clk);
      request = '0;
      wait_idle(4'b0101, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rr_timeout busy got=%0h exp=0", busy); end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= rd_addr_q.size() || rd_addr_q[i] !== ea[i]) begin
            failures++;
            $display("FAIL rr_order[%0d] got=%0h exp=%0h", i, (i < rd_addr_q.size()) ? rd_addr_q[i] : 32'hDEADBEEF, ea[i]);
         end
      end
      checks++;
      if (done_order.size() != 2 || done_order[0] != 2 || done_order[1] != 0) begin
         failures++;
         $display("FAIL rr_done_order got size=%0d first=%0d exp size=2 first=2 second=0", done_order.size(), (done_order.size() > 0) ? done_order[0] : -1);
      end
   endtask

   task automatic test_trigger();
      bit ok;
      bit stall_bad;
      apply_reset();
      load(1, 32'h3000, 32'hA000, 32'd3072);
      request[1] = 1'b1;
      @(negedge clk);
      request[1] = 1'b0;
      wait_mm2s(ok);
      trigger[1] = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL trig_grant_timeout got=0 exp=1"); end
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (rem[63:32] == 32'd2048) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++; if (!ok) begin failures++; $display("FAIL trig_sub1_timeout rem got=%0d exp=2048", rem[63:32]); end
      stall_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.o_mm2s_request !== 1'b0) stall_bad = 1'b1;
      end
      checks++; if (stall_bad) begin failures++; $display("FAIL trig_stall mm2s_request got=1 exp=0"); end
      checks++; if (rd_addr_q.size() != 1 || busy[1] !== 1'b1) begin failures++; $display("FAIL trig_hold rd/busy got=%0d/%0b exp=1/1", rd_addr_q.size(), busy[1]); end
      checks++; if (rem[63:32] !== 32'd2048) begin failures++; $display("FAIL trig_rem got=%0d exp=2048", rem[63:32]); end
      trigger[1] = 1'b1;
      @(negedge clk);
      checks++; if (bus.o_mm2s_request !== 1'b1 || bus.o_mm2s_addr !== 32'h3400) begin failures++; $display("FAIL trig_resume req/addr got=%0b/%0h exp=1/3400", bus.o_mm2s_request, bus.o_mm2s_addr); end
      wait_idle(4'b0010, ok);
      repeat (2) @(negedge clk);
      checks++; if (!ok || done_cnt[1] != 1 || rd_addr_q.size() != 3) begin failures++; $display("FAIL trig_finish done/rd got=%0d/%0d exp=1/3", done_cnt[1], rd_addr_q.size()); end
   endtask

   task automatic test_error();
      bit ok;
      apply_reset();
      load(0, 32'h40000, 32'h50000, 32'd2048);
      load(1, 32'h60000, 32'h70000, 32'd1024);
      request = 4'b0011;
      @(negedge clk);
      request = '0;
      wait_s2mm(ok);
      checks++; if (!ok || bus.o_s2mm_addr !== 32'h50000) begin failures++; $display("FAIL err_first_write addr got=%0h exp=50000", bus.o_s2mm_addr); end
      bus.i_s2mm_err = 1'b1;
      @(negedge clk);
      bus.i_s2mm_err = 1'b0;
      checks++; if (err[0] !== 1'b1 || busy[0] !== 1'b0) begin failures++; $display("FAIL err_flag err/busy got=%0b/%0b exp=1/0", err[0], busy[0]); end
      checks++; if (bus.o_s2mm_request !== 1'b0 || busy[1] !== 1'b1) begin failures++; $display("FAIL err_side s2mm_req/busy1 got=%0b/%0b exp=0/1", bus.o_s2mm_request, busy[1]); end
      wait_idle(4'b0010, ok);
      repeat (2) @(negedge clk);
      checks++; if (!ok || done_cnt[1] != 1 || err[1] !== 1'b0) begin failures++; $display("FAIL err_other done1/err1 got=%0d/%0b exp=1/0", done_cnt[1], err[1]); end
      checks++; if (done_cnt[0] != 0 || err[0] !== 1'b1) begin failures++; $display("FAIL err_sticky done0/err0 got=%0d/%0b exp=0/1", done_cnt[0], err[0]); end
      load(0, 32'h40000, 32'h50000, 32'd1024);
      request[0] = 1'b1;
      @(negedge clk);
      request[0] = 1'b0;
      checks++; if (err[0] !== 1'b0 || busy[0] !== 1'b1) begin failures++; $display("FAIL err_clear err/busy got=%0b/%0b exp=0/1", err[0], busy[0]); end
      wait_idle(4'b0001, ok);
   endtask

   task automatic test_abort();
      bit ok;
      apply_reset();
      load(0, 32'h1000, 32'h2000, 32'd2048);
      load(3, 32'h3000, 32'h4000, 32'd1024);
      trigger[3] = 1'b0;
      request = 4'b1001;
      @(negedge clk);
      request = '0;
      wait_mm2s(ok);
      abort_s[0] = 1'b1;
      @(negedge clk);
      abort_s[0] = 1'b0;
      wait_idle(4'b0001, ok);
      repeat (2) @(negedge clk);
      checks++; if (!ok || rd_addr_q.size() != 1 || wr_addr_q.size() != 1) begin failures++; $display("FAIL abort_finish rd/wr got=%0d/%0d exp=1/1", rd_addr_q.size(), wr_addr_q.size()); end
      checks++; if (done_cnt[0] != 0 || err[0] !== 1'b0) begin failures++; $display("FAIL abort_nodone done/err got=%0d/%0b exp=0/0", done_cnt[0], err[0]); end
      checks++; if (rem[31:0] !== 32'd1024) begin failures++; $display("FAIL abort_rem got=%0d exp=1024", rem[31:0]); end
      checks++; if (busy[3] !== 1'b1) begin failures++; $display("FAIL abort_ch3_waiting busy got=%0b exp=1", busy[3]); end
      abort_s[3] = 1'b1;
      @(negedge clk);
      abort_s[3] = 1'b0;
      checks++; if (busy[3] !== 1'b0) begin failures++; $display("FAIL abort_idle busy got=%0b exp=0", busy[3]); end
      @(negedge clk);
      checks++; if (done_cnt[3] != 0 || err[3] !== 1'b0) begin failures++; $display("FAIL abort_idle_flags done/err got=%0d/%0b exp=0/0", done_cnt[3], err[3]); end
      load(2, 32'h5000, 32'h6000, 32'd512);
      request[2] = 1'b1;
      abort_s[2] = 1'b1;
      @(negedge clk);
      request[2] = 1'b0;
      abort_s[2] = 1'b0;
      @(negedge clk);
      checks++; if (busy[2] !== 1'b0 || done_cnt[2] != 0) begin failures++; $display("FAIL abort_vs_request busy/done got=%0b/%0d exp=0/0", busy[2], done_cnt[2]); end
   endtask

   task automatic test_corners();
      bit ok;
      apply_reset();
      load(1, 32'h0, 32'h0, 32'd0);
      request[1] = 1'b1;
      @(negedge clk);
      request[1] = 1'b0;
      checks++; if (done[1] !== 1'b1 || busy[1] !== 1'b0) begin failures++; $display("FAIL zero_len done/busy got=%0b/%0b exp=1/0", done[1], busy[1]); end
      @(negedge clk);
      checks++; if (done[1] !== 1'b0) begin failures++; $display("FAIL zero_len_pulse done got=%0b exp=0", done[1]); end

      bus.i_mm2s_inc = 1'b0;
      load(0, 32'h5000, 32'h9000, 32'd2048);
      request[0] = 1'b1;
      @(negedge clk);
      request[0] = 1'b0;
      wait_idle(4'b0001, ok);
      repeat (2) @(negedge clk);
      checks++;
      if (!ok || rd_addr_q.size() != 2 || rd_addr_q[0] !== 32'h5000 || rd_addr_q[1] !== 32'h5000) begin
         failures++;
         $display("FAIL noinc_src got=%0h exp=5000 (n=%0d)", (rd_addr_q.size() > 1) ? rd_addr_q[1] : 32'hDEADBEEF, rd_addr_q.size());
      end
      checks++; if (wr_addr_q.size() != 2 || wr_addr_q[1] !== 32'h9400) begin failures++; $display("FAIL noinc_dst got=%0h exp=9400", (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'hDEADBEEF); end

      apply_reset();
      tl = '0;
      load(2, 32'hFFFFFC00, 32'h100, 32'd2048);
      request[2] = 1'b1;
      @(negedge clk);
      request[2] = 1'b0;
      wait_idle(4'b0100, ok);
      repeat (2) @(negedge clk);
      checks++;
      if (!ok || rd_addr_q.size() != 2 || rd_addr_q[0] !== 32'hFFFFFC00 || rd_addr_q[1] !== 32'h0) begin
         failures++;
         $display("FAIL wrap_src got=%0h exp=0 (n=%0d)", (rd_addr_q.size() > 1) ? rd_addr_q[1] : 32'hDEADBEEF, rd_addr_q.size());
      end
      checks++; if (rd_len_q.size() < 1 || rd_len_q[0] !== 11'd1024) begin failures++; $display("FAIL tl_zero_len got=%0d exp=1024", (rd_len_q.size() > 0) ? rd_len_q[0] : 11'h0); end

      apply_reset();
      load(0, 32'h1000, 32'h2000, 32'd1024);
      request[0] = 1'b1;
      @(negedge clk);
      request[0] = 1'b0;
      wait_s2mm(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rst_mid_write_reach got=0 exp=1"); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 4'h0 || done !== 4'h0 || err !== 4'h0) begin failures++; $display("FAIL rst_mid_flags got=%0h/%0h/%0h exp=0/0/0", busy, done, err); end
      checks++; if (bus.o_s2mm_request !== 1'b0 || bus.o_s2mm_addr !== 32'h0 || bus.o_s2mm_transferlen !== 11'h0) begin failures++; $display("FAIL rst_mid_bus got=%0b/%0h/%0h exp=0/0/0", bus.o_s2mm_request, bus.o_s2mm_addr, bus.o_s2mm_transferlen); end
      checks++; if (rem !== '0) begin failures++; $display("FAIL rst_mid_rem got=%0h exp=0", rem); end
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_trigger();
      test_error();
      test_abort();
      test_corners();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
